// File: rtl/pipeline_hazard_ctrl.sv
// Hazard sequencer for the 5-stage MIPS32 pipeline without forwarding:
// RAW stalls, MEM-stage redirect squash, debug halt/step, perf counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W     = 16,
  parameter bit WB_BYPASS = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rs,
  input  logic             id_uses_rt,
  input  logic [4:0]       ex_wreg,
  input  logic             ex_reg_write,
  input  logic [4:0]       mem_wreg,
  input  logic             mem_reg_write,
  input  logic [4:0]       wb_wreg,
  input  logic             wb_reg_write,
  input  logic             mem_branch_taken,
  input  logic             mem_jump,
  input  logic             dbg_halt,
  input  logic             dbg_step,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_HALT = 2'd1,
    S_STEP = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};

  state_t           r_state;
  logic [CNT_W-1:0] r_stall;
  logic [CNT_W-1:0] r_flush;

  logic w_hz_rs;
  logic w_hz_rt;
  logic w_raw;
  logic w_redir;
  logic w_active;

  // WB producer only matters when the register file cannot write-then-read
  assign w_hz_rs = (id_rs != 5'd0) &
                   ((ex_reg_write & (ex_wreg == id_rs)) |
                    (mem_reg_write & (mem_wreg == id_rs)) |
                    (!WB_BYPASS & wb_reg_write & (wb_wreg == id_rs)));

  assign w_hz_rt = (id_rt != 5'd0) &
                   ((ex_reg_write & (ex_wreg == id_rt)) |
                    (mem_reg_write & (mem_wreg == id_rt)) |
                    (!WB_BYPASS & wb_reg_write & (wb_wreg == id_rt)));

  assign w_raw    = (id_uses_rs & w_hz_rs) | (id_uses_rt & w_hz_rt);
  assign w_redir  = mem_branch_taken | mem_jump;
  assign w_active = (r_state != S_HALT);

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    if (reset) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (!w_active) begin
      pc_en    = 1'b0;
      ifid_en  = 1'b0;
      idex_en  = 1'b0;
      exmem_en = 1'b0;
      memwb_en = 1'b0;
    end else if (w_redir) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (w_raw) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_RUN;
    end else begin
      case (r_state)
        S_RUN:   r_state <= dbg_halt ? S_HALT : S_RUN;
        S_HALT: begin
          if (dbg_step)       r_state <= S_STEP;
          else if (!dbg_halt) r_state <= S_RUN;
          else                r_state <= S_HALT;
        end
        S_STEP:  r_state <= dbg_halt ? S_HALT : S_RUN;
        default: r_state <= S_RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall <= '0;
      r_flush <= '0;
    end else if (w_active) begin
      if (w_redir) begin
        if (r_flush != MAX) r_flush <= r_flush + ONE;
      end else if (w_raw) begin
        if (r_stall != MAX) r_stall <= r_stall + ONE;
      end
    end
  end

  assign state_o   = r_state;
  assign stall_cnt = r_stall;
  assign flush_cnt = r_flush;

endmodule
